times_table_sequencer: RTL and testbench

Operand-sweep generator that sits directly upstream of the times-table multiplier. On a start pulse it walks every (a, b) operand pair exactly once and drives the multiplier's `a`, `b` and `enable` inputs: `a` is the fast index and `b` is the slow index. It honours a `hold` back-pressure input without skipping or duplicating any pair. It reports progress through `busy`, `done` and a consumed-pair count.

---
 rtl/tt_pkg.sv | 13 +
 rtl/tt_operand_counter.sv | 41 ++++
 rtl/times_table_sequencer.sv | 98 +++++++++
 tb/tb_times_table_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the times-table sequencer and multiplier.
// State encoding plus the default operand width.
package tt_pkg;

    localparam int TT_WIDTH = 3;

    typedef enum logic [1:0] {
        TT_IDLE = 2'd0,
        TT_RUN  = 2'd1,
        TT_DONE = 2'd2
    } tt_state_e;

endpackage

// File: rtl/tt_operand_counter.sv
// Nested operand counter: a is the fast index, b the slow index.
// Reset clears to zero; load restarts the sweep at FIRST.
module tt_operand_counter
    import tt_pkg::*;
#(
    parameter int WIDTH = TT_WIDTH,
    parameter int FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             advance,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             last
);

    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] FV   = WIDTH'(FIRST);
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a <= '0;
            b <= '0;
        end else if (load) begin
            a <= FV;
            b <= FV;
        end else if (advance) begin
            if (a == MAXV) begin
                a <= FV;
                b <= b + ONE;
            end else begin
                a <= a + ONE;
            end
        end
    end

    assign last = (a == MAXV) && (b == MAXV);

endmodule

// File: rtl/times_table_sequencer.sv
// Operand-sweep generator feeding the times-table multiplier.
// Define TT_SEQ_SKIP_ZERO_EN to skip zero operands (sweep 1..max).
module times_table_sequencer
    import tt_pkg::*;
#(
    parameter int WIDTH = TT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hold,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    output logic               enable,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   count
);

`ifdef TT_SEQ_SKIP_ZERO_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    localparam logic [1:0] IDLE = TT_IDLE;
    localparam logic [1:0] RUN  = TT_RUN;
    localparam logic [1:0] DONE = TT_DONE;

    localparam logic [2*WIDTH:0] CNT_ONE = {{(2*WIDTH){1'b0}}, 1'b1};

    logic [1:0] state;
    logic       load;
    logic       advance;
    logic       last;

    assign load = (state == IDLE) && start;
    // The final pair stays on a/b after consumption, so never advance past it.
    assign advance = (state == RUN) && enable && !last;

    tt_operand_counter #(
        .WIDTH (WIDTH),
        .FIRST (FIRST)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .advance (advance),
        .a       (a),
        .b       (b),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        enable <= 1'b1;
                        busy   <= 1'b1;
                        count  <= '0;
                    end
                end
                RUN: begin
                    if (enable) begin
                        count <= count + CNT_ONE;
                    end
                    if (enable && last) begin
                        state  <= DONE;
                        enable <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        enable <= !hold;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_times_table_sequencer.sv
// Scoreboard bench for times_table_sequencer (WIDTH=3).
// Expected pairs are queued by stimulus and popped by a monitor.
module tb_times_table_sequencer;

    localparam int W    = 3;
    localparam int MAXV = 7;
`ifdef TT_SEQ_SKIP_ZERO_EN
    localparam int FV = 1;
`else
    localparam int FV = 0;
`endif
    localparam int NP = (MAXV - FV + 1) * (MAXV - FV + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           hold;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           enable;
    logic           busy;
    logic           done;
    logic [2*W:0]   count;

    times_table_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .hold   (hold),
        .a      (a),
        .b      (b),
        .enable (enable),
        .busy   (busy),
        .done   (done),
        .count  (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_seen = 0;
    int stall = 0;
    logic mon_en = 1'b0;
    logic [2*W-1:0] sb_q[$];
    logic [2*W-1:0] mexp;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (enable) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pair", 1, 0);
                end else begin
                    mexp = sb_q.pop_front();
                    chk("pair_a", int'(a), int'(mexp[W-1:0]));
                    chk("pair_b", int'(b), int'(mexp[2*W-1:W]));
                end
                chk("busy_in_run", int'(busy), 1);
            end else if (busy) begin
                stall++;
            end
            if (done) begin
                done_seen++;
                chk("done_count", int'(count), NP);
                chk("done_busy", int'(busy), 0);
                chk("done_a", int'(a), MAXV);
                chk("done_b", int'(b), MAXV);
                chk("done_queue_empty", sb_q.size(), 0);
            end
        end
    end

    task automatic push_all();
        for (int j = FV; j <= MAXV; j++)
            for (int i = FV; i <= MAXV; i++)
                sb_q.push_back({W'(j), W'(i)});
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_a"}, int'(a), 0);
        chk({nm, "_b"}, int'(b), 0);
        chk({nm, "_enable"}, int'(enable), 0);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_done"}, int'(done), 0);
        chk({nm, "_count"}, int'(count), 0);
    endtask

    task automatic run_sweep(input int do_hold, input int busy_start);
        int lat;
        int hold_left;
        int hold_used;
        int done0;
        int en_seen;
        int ok;
        lat = 0;
        hold_left = 0;
        hold_used = 0;
        en_seen = 0;
        ok = 0;
        done0 = done_seen;
        push_all();
        @(negedge clk);
        stall = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
            start = (busy_start != 0) && (lat == 20);
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) hold = 1'b0;
            end else if (do_hold != 0 && hold_used == 0 &&
                         enable && a == W'(2) && b == W'(2)) begin
                hold = 1'b1;
                hold_left = 3;
                hold_used = 1;
            end
        end
        start = 1'b0;
        hold = 1'b0;
        chk("sweep_finished", ok, 1);
        chk("latency", lat, NP + 3 * do_hold);
        chk("stall_cycles", stall, 3 * do_hold);
        if (busy_start != 0) begin
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        repeat (5) begin
            @(negedge clk);
            if (enable) en_seen = 1;
        end
        chk("no_restart", en_seen, 0);
        chk("done_pulses", done_seen - done0, 1);
        chk("idle_count_kept", int'(count), NP);
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);
    endtask

    initial begin
        int found;
        rst = 1'b1;
        start = 1'b0;
        hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_zero("reset");
            @(negedge clk);
        end
        mon_en = 1'b1;

        run_sweep(0, 0);
        run_sweep(1, 0);
        run_sweep(0, 1);

        push_all();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (enable && a == W'(5) && b == W'(4)) begin
                found = 1;
                break;
            end
        end
        chk("reach_5_4", found, 1);
        #2 rst = 1'b1;
        #1 chk_zero("mid_reset");
        sb_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 chk_zero("rst_beats_start");
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_zero("after_reset");

        run_sweep(0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
